spi_sensor_reader: RTL and testbench

SPI_SENSOR_READER -- requirements
Module: spi_sensor_reader

---
 rtl/spi_sensor_reader.sv | 119 +++++++++++
 tb/tb_spi_sensor_reader.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/spi_sensor_reader.sv
// spi_sensor_reader: SPI mode-0 master that sends a command then captures a sensor response word.
module spi_sensor_reader #(
    parameter int CLK_DIV   = 4,
    parameter int CMD_BITS  = 8,
    parameter int DATA_BITS = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [CMD_BITS-1:0]  cmd,
    output logic                 busy,
    output logic                 done,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 spi_sck,
    output logic                 spi_cs,
    output logic                 spi_mosi,
    input  logic                 spi_miso
);
    localparam int NB = CMD_BITS + DATA_BITS;
    localparam int HW = $clog2(2 * NB);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    state_t               state, state_n;
    logic [7:0]           cnt, cnt_n;
    logic [HW-1:0]        hp, hp_n;
    logic [CMD_BITS-1:0]  sh, sh_n;
    logic [DATA_BITS-1:0] rx, rx_n, data_n;
    logic                 sck_n, cs_n, mosi_n, busy_n, done_n, last;

    assign last = cnt == 8'(CLK_DIV - 1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            hp       <= '0;
            sh       <= '0;
            rx       <= '0;
            data_out <= '0;
            spi_sck  <= 1'b0;
            spi_cs   <= 1'b1;
            spi_mosi <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            hp       <= hp_n;
            sh       <= sh_n;
            rx       <= rx_n;
            data_out <= data_n;
            spi_sck  <= sck_n;
            spi_cs   <= cs_n;
            spi_mosi <= mosi_n;
            busy     <= busy_n;
            done     <= done_n;
        end
    end

    // hp counts SCK half-periods in SHIFT: even = high, odd = low
    always_comb begin
        state_n = state;
        cnt_n   = last ? 8'd0 : cnt + 8'd1;
        hp_n    = hp;
        sh_n    = sh;
        rx_n    = rx;
        data_n  = data_out;
        sck_n   = spi_sck;
        cs_n    = spi_cs;
        mosi_n  = spi_mosi;
        busy_n  = busy;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (start) begin
                    state_n = SETUP;
                    sh_n    = cmd;
                    cs_n    = 1'b0;
                    mosi_n  = cmd[CMD_BITS-1];
                    busy_n  = 1'b1;
                end
            end
            SETUP: if (last) begin
                state_n = SHIFT;
                hp_n    = '0;
                sck_n   = 1'b1;
                rx_n    = {rx[DATA_BITS-2:0], spi_miso};
            end
            SHIFT: if (last) begin
                if (hp == HW'(2 * NB - 1)) begin
                    state_n = HOLD;
                end else begin
                    hp_n  = hp + HW'(1);
                    sck_n = ~spi_sck;
                    if (spi_sck) begin
                        sh_n   = sh << 1;
                        mosi_n = sh[CMD_BITS-2];
                    end else begin
                        rx_n = {rx[DATA_BITS-2:0], spi_miso};
                    end
                end
            end
            HOLD: if (last) begin
                state_n = GAP;
                cs_n    = 1'b1;
                mosi_n  = 1'b0;
                done_n  = 1'b1;
                data_n  = rx;
            end
            GAP: if (last) begin
                state_n = IDLE;
                busy_n  = 1'b0;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_spi_sensor_reader.sv
// tb_spi_sensor_reader: directed checks of spi_sensor_reader at CLK_DIV=4 and CLK_DIV=2 against a mode-0 sensor model.
module tb_spi_sensor_reader;
    logic        clk = 1'b0;
    logic        reset, start, start2;
    logic [7:0]  cmd, cmd2;
    logic        busy, done, sck, cs, mosi, miso;
    logic        busy2, done2, sck2, cs2, mosi2, miso2;
    logic [15:0] data_out, data2, word1, word2;

    always #5 clk = ~clk;

    spi_sensor_reader dut (
        .clk(clk), .reset(reset), .start(start), .cmd(cmd), .busy(busy), .done(done),
        .data_out(data_out), .spi_sck(sck), .spi_cs(cs), .spi_mosi(mosi), .spi_miso(miso)
    );

    spi_sensor_reader #(.CLK_DIV(2)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .cmd(cmd2), .busy(busy2), .done(done2),
        .data_out(data2), .spi_sck(sck2), .spi_cs(cs2), .spi_mosi(mosi2), .spi_miso(miso2)
    );

    // sensor: 8 garbage ones during the command phase, then the word, shifted on SCK falls
    int idx1 = 0, idx2 = 0;
    logic [23:0] resp1, resp2;
    assign resp1 = {8'hFF, word1};
    assign resp2 = {8'hFF, word2};
    assign miso  = idx1 < 24 ? resp1[23 - idx1] : 1'b0;
    assign miso2 = idx2 < 24 ? resp2[23 - idx2] : 1'b0;
    always @(negedge sck or posedge cs)  idx1 = cs  ? 0 : idx1 + 1;
    always @(negedge sck2 or posedge cs2) idx2 = cs2 ? 0 : idx2 + 1;

    int rises1 = 0, rises2 = 0;
    logic [23:0] mcap1 = '0, mcap2 = '0;
    always @(posedge sck)  begin rises1++; mcap1 = {mcap1[22:0], mosi};  end
    always @(posedge sck2) begin rises2++; mcap2 = {mcap2[22:0], mosi2}; end

    int prot1 = 0, prot2 = 0, m2ones = 0;
    logic pm1 = 1'b0, pm2 = 1'b0;
    always @(negedge clk) begin
        if (sck && mosi != pm1) prot1++;
        if (cs && sck) prot1++;
        if (done && !(cs && busy)) prot1++;
        pm1 = mosi;
    end
    always @(negedge clk) begin
        if (sck2 && mosi2 != pm2) prot2++;
        if (cs2 && sck2) prot2++;
        if (done2 && !(cs2 && busy2)) prot2++;
        if (mosi2) m2ones++;
        pm2 = mosi2;
    end

    int n_chk = 0, n_pass = 0;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    // one read on dut, starting from a negedge; optional start pulses and reset injection
    task automatic run1(input logic [7:0] c, input logic [15:0] w, input int p1, input int p2,
                        input int rst_at, output int d_at, output int cs_low, output int bl_at,
                        output int nr);
        int r0;
        logic [15:0] prev;
        r0 = rises1; prev = data_out; cmd = c; word1 = w;
        d_at = 0; cs_low = 0; bl_at = 0; start = 1'b1;
        for (int r = 1; r <= 260 && bl_at == 0; r++) begin
            @(negedge clk);
            start = (r == p1) || (r == p2);
            cmd = ~c;
            if (r == rst_at) reset = 1'b1;
            if (r == rst_at + 1) begin
                chk("abort_cs", cs, 1);
                chk("abort_data", data_out, 0);
                reset = 1'b0;
            end
            if (r == 150) chk("data_hold", data_out, prev);
            if (!cs) cs_low++;
            if (done && d_at == 0) d_at = r;
            if (!busy) bl_at = r;
        end
        nr = rises1 - r0;
    endtask

    initial begin
        int d_at, cs_low, bl_at, nr, d1, d2, gap, ra, rb;
        logic ps;
        reset = 1'b1; start = 1'b0; cmd = '0; start2 = 1'b0; cmd2 = '0; word1 = '0; word2 = '0;
        repeat (3) @(negedge clk);
        chk("rst_cs", cs, 1);
        chk("rst_sck", sck, 0);
        chk("rst_mosi", mosi, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_data", data_out, 0);
        start = 1'b1;
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("rst_prio_busy", busy, 0);
        chk("rst_prio_cs", cs, 1);

        run1(8'hA5, 16'hBEEF, 0, 0, 999, d_at, cs_low, bl_at, nr);
        chk("a_done_at", d_at, 201);
        chk("a_cs_low", cs_low, 200);
        chk("a_busy_low", bl_at, 205);
        chk("a_rises", nr, 24);
        chk("a_mosi", mcap1, 24'hA50000);
        chk("a_data", data_out, 16'hBEEF);

        run1(8'h3C, 16'h1234, 50, 100, 999, d_at, cs_low, bl_at, nr);
        chk("ign_done_at", d_at, 201);
        chk("ign_rises", nr, 24);
        chk("ign_mosi", mcap1, 24'h3C0000);
        chk("ign_data", data_out, 16'h1234);

        run1(8'h5A, 16'h7777, 0, 0, 120, d_at, cs_low, bl_at, nr);
        chk("abort_no_done", d_at, 0);
        chk("abort_idle_at", bl_at, 121);
        run1(8'h81, 16'hCAFE, 0, 0, 999, d_at, cs_low, bl_at, nr);
        chk("post_done_at", d_at, 201);
        chk("post_mosi", mcap1, 24'h810000);
        chk("post_data", data_out, 16'hCAFE);

        cmd = 8'h11; word1 = 16'h0001; start = 1'b1; d1 = 0; d2 = 0; gap = 0;
        for (int r = 1; r <= 500 && d2 == 0; r++) begin
            @(negedge clk);
            if (done && d1 == 0) begin
                d1 = r;
                chk("b2b_data1", data_out, 16'h0001);
                word1 = 16'h8000;
            end else if (done) begin
                d2 = r;
                chk("b2b_data2", data_out, 16'h8000);
                start = 1'b0;
            end
            if (d1 != 0 && d2 == 0 && cs) gap++;
        end
        chk("b2b_first", d1, 201);
        chk("b2b_spacing", d2 - d1, 205);
        chk("b2b_cs_gap", gap, 5);
        for (int i = 0; i < 20 && busy; i++) @(negedge clk);
        chk("b2b_idle", busy, 0);

        cmd2 = 8'h00; word2 = 16'hFFFF; start2 = 1'b1; d2 = 0; ra = 0; rb = 0; ps = 1'b0; nr = rises2;
        for (int r = 1; r <= 200 && d2 == 0; r++) begin
            @(negedge clk);
            start2 = 1'b0;
            if (sck2 && !ps) begin
                if (ra == 0) ra = r;
                else if (rb == 0) rb = r;
            end
            ps = sck2;
            if (done2) d2 = r;
        end
        chk("d2_period", rb - ra, 4);
        chk("d2_done_at", d2, 101);
        chk("d2_rises", rises2 - nr, 24);
        chk("d2_data", data2, 16'hFFFF);
        chk("d2_mosi_zero", m2ones, 0);
        for (int i = 0; i < 20 && busy2; i++) @(negedge clk);

        chk("protocol_dut", prot1, 0);
        chk("protocol_dut2", prot2, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
